// File: rtl/intersection_scheduler.sv
// Highway/country intersection light controller with pedestrian walk service.
// Latency: inputs act at the next clk edge. Backpressure: none, sensors are sampled every cycle.
module intersection_scheduler #(
  parameter int MIN_GRN = 8,
  parameter int MAX_GRN = 30,
  parameter int YEL_T   = 3,
  parameter int CLR_T   = 2,
  parameter int CW      = 6
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       cntry_req,
  input  logic       ped_req,
  output logic [1:0] hwy,
  output logic [1:0] cntry,
  output logic       walk,
  output logic [2:0] phase,
  output logic       ped_pend
);

  typedef enum logic [2:0] {
    HG  = 3'd0,
    HY  = 3'd1,
    AR1 = 3'd2,
    CG  = 3'd3,
    CY  = 3'd4,
    AR2 = 3'd5
  } state_t;

  localparam logic [1:0] RED = 2'd0, YELLOW = 2'd1, GREEN = 2'd2;
  localparam logic [CW-1:0] MIN_M1  = CW'(MIN_GRN - 1);
  localparam logic [CW-1:0] MAX_M1  = CW'(MAX_GRN - 1);
  localparam logic [CW-1:0] YEL_M1  = CW'(YEL_T - 1);
  localparam logic [CW-1:0] CLR_M1  = CW'(CLR_T - 1);
  localparam logic [CW-1:0] TMR_SAT = {CW{1'b1}};

  state_t        state;
  logic [CW-1:0] tmr;
  logic          walk_srv;
  logic          leave;

  always_comb begin
    leave = 1'b0;
    case (state)
      HG:       leave = (tmr >= MIN_M1) && (cntry_req || ped_pend);
      HY, CY:   leave = (tmr == YEL_M1);
      AR1, AR2: leave = (tmr == CLR_M1);
      CG:       leave = (tmr >= MIN_M1) && (!cntry_req || tmr >= MAX_M1);
      default:  leave = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state    <= HG;
      tmr      <= '0;
      ped_pend <= 1'b0;
      walk_srv <= 1'b0;
    end else begin
      if (leave) begin
        tmr <= '0;
        case (state)
          HG:      state <= HY;
          HY:      state <= AR1;
          AR1:     state <= CG;
          CG:      state <= CY;
          CY:      state <= AR2;
          default: state <= HG;
        endcase
      end else if (tmr != TMR_SAT) begin
        tmr <= tmr + CW'(1);
      end
      // Entering CG serves the pending request, including one arriving on this very edge.
      if (state == AR1 && leave) begin
        ped_pend <= 1'b0;
        walk_srv <= ped_pend | ped_req;
      end else begin
        if (ped_req) ped_pend <= 1'b1;
        if (state == CG && leave) walk_srv <= 1'b0;
      end
    end
  end

  always_comb begin
    hwy   = RED;
    cntry = RED;
    phase = 3'd0;
    case (state)
      HG:  begin hwy = GREEN;    phase = 3'd0; end
      HY:  begin hwy = YELLOW;   phase = 3'd1; end
      AR1: phase = 3'd2;
      CG:  begin cntry = GREEN;  phase = 3'd3; end
      CY:  begin cntry = YELLOW; phase = 3'd4; end
      AR2: phase = 3'd5;
      default: begin hwy = GREEN; phase = 3'd0; end
    endcase
  end

  assign walk = (state == CG) && walk_srv;

endmodule

// File: tb/tb_intersection_scheduler.sv
// Directed scenarios plus randomized traffic checked against a phase/duration model.
module tb_intersection_scheduler;
  localparam int MIN_GRN = 8, MAX_GRN = 30, YEL_T = 3, CLR_T = 2, CW = 6;

  logic clk = 1'b0;
  logic clear = 1'b1, cntry_req = 1'b0, ped_req = 1'b0;
  logic [1:0] hwy, cntry;
  logic walk, ped_pend;
  logic [2:0] phase;

  int n_chk = 0, n_pass = 0;

  // Reference model: which phase we are in, how long we have been in it.
  int m_ph = 0, m_cnt = 0;
  bit m_pend = 0, m_srv = 0;

  intersection_scheduler #(.MIN_GRN(MIN_GRN), .MAX_GRN(MAX_GRN), .YEL_T(YEL_T),
                           .CLR_T(CLR_T), .CW(CW)) dut (
    .clk(clk), .clear(clear), .cntry_req(cntry_req), .ped_req(ped_req),
    .hwy(hwy), .cntry(cntry), .walk(walk), .phase(phase), .ped_pend(ped_pend)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic bit model_leaves(input bit creq);
    case (m_ph)
      0: return (m_cnt >= MIN_GRN - 1) && (creq || m_pend);
      1, 4: return m_cnt + 1 >= YEL_T;
      2, 5: return m_cnt + 1 >= CLR_T;
      3: return (m_cnt >= MIN_GRN - 1) && (!creq || m_cnt >= MAX_GRN - 1);
      default: return 1'b1;
    endcase
  endfunction

  task automatic model_step(input bit creq, input bit preq, input bit clr);
    bit lv, to_cg;
    if (clr) begin
      m_ph = 0; m_cnt = 0; m_pend = 0; m_srv = 0;
      return;
    end
    lv = model_leaves(creq);
    to_cg = lv && (m_ph == 2);
    if (to_cg) begin
      m_srv = m_pend | preq;
      m_pend = 0;
    end else begin
      m_pend = m_pend | preq;
      if (lv && m_ph == 3) m_srv = 0;
    end
    if (lv) begin
      m_ph = (m_ph + 1) % 6;
      m_cnt = 0;
    end else m_cnt++;
  endtask

  task automatic tick(input bit creq, input bit preq, input bit clr);
    int e_hwy, e_cntry;
    cntry_req = creq; ped_req = preq; clear = clr;
    @(posedge clk);
    model_step(creq, preq, clr);
    #1;
    e_hwy   = (m_ph == 0) ? 2 : (m_ph == 1) ? 1 : 0;
    e_cntry = (m_ph == 3) ? 2 : (m_ph == 4) ? 1 : 0;
    chk("hwy", hwy, e_hwy);
    chk("cntry", cntry, e_cntry);
    chk("phase", phase, m_ph);
    chk("ped_pend", ped_pend, m_pend);
    chk("walk", walk, (m_ph == 3) && m_srv);
    chk("both_nonred", (hwy != 0) && (cntry != 0), 0);
    chk("walk_hwy_nonred", walk && (hwy != 0), 0);
  endtask

  task automatic run_to(input int ph, input bit creq);
    int n = 0;
    while (phase != ph && n < 200) begin tick(creq, 0, 0); n++; end
    chk("run_to_timeout", phase, ph);
  endtask

  task automatic measure(input int ph, input bit creq, output int len);
    len = 0;
    while (phase == ph && len < 100) begin tick(creq, 0, 0); len++; end
  endtask

  initial begin
    int len, n, wcnt;
    bit creq;

    // Reset and CG entry timing
    tick(1, 0, 1);
    chk("rst_phase", phase, 0); chk("rst_hwy", hwy, 2); chk("rst_cntry", cntry, 0);
    chk("rst_walk", walk, 0); chk("rst_pend", ped_pend, 0);
    n = 0;
    while (phase != 3 && n < 40) begin tick(1, 0, 0); n++; end
    chk("cg_entry_cycle", n, 13);

    // Continuous country demand
    measure(3, 1, len); chk("cg_max_len", len, 30);
    measure(4, 1, len); chk("cy_len", len, 3);
    measure(5, 1, len); chk("ar2_len", len, 2);
    measure(0, 1, len); chk("hg_min_len", len, 8);

    // Demand drops at CG tmr=3
    run_to(3, 1);
    repeat (3) tick(1, 0, 0);
    measure(3, 0, len); chk("cg_drop_len", len + 3, 8);

    // Clear held two cycles while in CY
    run_to(4, 1);
    tick(0, 0, 1); tick(0, 0, 1);
    chk("clr_phase", phase, 0); chk("clr_hwy", hwy, 2); chk("clr_cntry", cntry, 0);
    chk("clr_walk", walk, 0); chk("clr_pend", ped_pend, 0);

    // Single pedestrian pulse at HG tmr=10
    repeat (10) tick(0, 0, 0);
    tick(0, 1, 0);
    chk("ped_latch", ped_pend, 1); chk("ped_still_hg", phase, 0);
    tick(0, 0, 0);
    chk("ped_to_hy", phase, 1);
    run_to(3, 0);
    chk("ped_cleared_cg", ped_pend, 0);
    len = 0; wcnt = 0;
    while (phase == 3 && len < 100) begin wcnt += walk; tick(0, 0, 0); len++; end
    chk("ped_cg_len", len, 8); chk("ped_walk_cycles", wcnt, 8);

    // Pedestrian on AR1->CG edge and again at CG tmr=2
    run_to(0, 0);
    run_to(2, 1);
    tick(1, 0, 0);
    tick(0, 1, 0);
    chk("edge_walk", walk, 1); chk("edge_absorbed", ped_pend, 0);
    tick(0, 0, 0); tick(0, 0, 0);
    tick(0, 1, 0);
    chk("cg_ped_latch", ped_pend, 1); chk("cg_walk_held", walk, 1);
    measure(3, 0, len); chk("cg_not_extended", len + 3, 8);
    run_to(0, 0);
    measure(0, 0, len); chk("hg_before_second", len, 8);
    run_to(3, 0);
    chk("second_walk", walk, 1);

    // Randomized traffic
    creq = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) creq = ~creq;
      tick(creq, $urandom_range(0, 24) == 0, $urandom_range(0, 499) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/intersection_scheduler.md
INTERSECTION_SCHEDULER -- requirements
Module: intersection_scheduler

Interface
REQ-001 The block SHALL have parameter MIN_GRN, default 8, minimum green duration in clk cycles for either road.
REQ-002 The block SHALL have parameter MAX_GRN, default 30, maximum country-green duration in cycles.
REQ-003 The block SHALL have parameter YEL_T, default 3, yellow duration in cycles.
REQ-004 The block SHALL have parameter CLR_T, default 2, all-red clearance duration in cycles.
REQ-005 The block SHALL have parameter CW, default 6, phase timer width.
REQ-006 Legal parameters SHALL satisfy 1 <= MIN_GRN <= MAX_GRN <= 2^CW-1; YEL_T, CLR_T >= 1 and <= 2^CW-1.
REQ-007 The block SHALL have port clk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-008 The block SHALL have port clear, input, 1, synchronous active-high reset.
REQ-009 The block SHALL have port cntry_req, input, 1, country-road vehicle sensor, level.
REQ-010 The block SHALL have port ped_req, input, 1, pedestrian button, may be a single-cycle pulse.
REQ-011 The block SHALL have port hwy, output, 2, highway light: RED=0, YELLOW=1, GREEN=2.
REQ-012 The block SHALL have port cntry, output, 2, country light, same encoding.
REQ-013 The block SHALL have port walk, output, 1, pedestrian walk signal across the highway.
REQ-014 The block SHALL have port phase, output, 3, current state encoding.
REQ-015 The block SHALL have port ped_pend, output, 1, latched, unserved pedestrian request.

Function
REQ-016 The state machine SHALL have states HG=0 (hwy GREEN, cntry RED), HY=1 (YELLOW/RED), AR1=2 (RED/RED), CG=3 (RED/GREEN), CY=4 (RED/YELLOW), AR2=5 (RED/RED); codes 6-7 SHALL decode as HG and transition to HG next cycle.
REQ-017 hwy, cntry and phase SHALL be Moore outputs decoded from the registered state only.
REQ-018 Timer tmr SHALL be 0 in the first cycle of every state, increment by 1 each cycle the state is held, and saturate at 2^CW-1.
REQ-019 HG->HY SHALL occur when tmr >= MIN_GRN-1 and (cntry_req or ped_pend); otherwise HG holds indefinitely.
REQ-020 HY->AR1 and CY->AR2 SHALL occur when tmr == YEL_T-1.
REQ-021 AR1->CG and AR2->HG SHALL occur when tmr == CLR_T-1.
REQ-022 CG->CY SHALL occur when tmr >= MIN_GRN-1 and (cntry_req == 0 or tmr >= MAX_GRN-1).
REQ-023 ped_pend SHALL be set by ped_req in any state and cleared on the AR1->CG transition; ped_req in that same cycle SHALL be absorbed (ped_pend stays 0).
REQ-024 On AR1->CG, internal flag walk_srv SHALL be set if ped_pend or ped_req is 1; walk_srv SHALL clear on leaving CG.
REQ-025 walk SHALL equal (state == CG) and walk_srv, and SHALL never be 1 while hwy != RED.
REQ-026 ped_req during CG SHALL set ped_pend and be served in the next CG phase, not extend the current one.
REQ-027 No state SHALL permit hwy and cntry both non-RED.

Reset
REQ-028 While clear is 1 at a rising edge, the next state SHALL be HG with tmr=0, ped_pend=0, walk_srv=0, giving hwy=2, cntry=0, walk=0, phase=0; clear SHALL override all inputs in every state.

Verification
REQ-029 Reset: clear=1 for 2 cycles while in CY -> cycle after: phase=0, hwy=2, cntry=0, walk=0, ped_pend=0.
REQ-030 cntry_req=1 from cycle 0 after reset -> HG cycles 0-7, HY 8-10, AR1 11-12, CG begins cycle 13.
REQ-031 cntry_req held continuously -> CG lasts exactly 30 cycles, then CY 3, AR2 2, then HG lasting exactly 8 cycles before HY.
REQ-032 cntry_req drops at CG tmr=3 -> CG still lasts exactly 8 cycles.
REQ-033 One-cycle ped_req in HG at tmr=10, cntry_req=0 -> ped_pend=1 next cycle, HY next, CG 8 cycles with walk=1 throughout, ped_pend=0 from CG entry.
REQ-034 ped_req on the AR1->CG edge and again at CG tmr=2 -> walk=1 this CG, ped_pend=1 after tmr=2, a second country phase follows after HG min green.
